ram_n_clr: RTL and testbench
============================

// Module: ram_n_clr
// PURPOSE
//  Parametrised Hack-style RAM (WIDTH x 2**ADDR_W) with a built-in clear engine.
//  Successor to the fixed RAM8..RAM16K stack: one generic array replaces the
//  DMUX/MUX tree. After reset, or on request, an FSM sweeps every word to zero
//  while busy is high. Sits under the CPU data-memory map wherever RAMn is used.
// PARAMETERS
//  WIDTH   16  data word width in bits
//  ADDR_W  9   address width; DEPTH = 2**ADDR_W words (9 -> 512, RAM512-equivalent)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  in           in   WIDTH   write data
//  address      in   ADDR_W  read/write address
//  load         in   1       write enable, sampled on clk rise
//  clear        in   1       request full-array zero sweep (level-sampled)
//  out          out  WIDTH   word at address (combinational read)
//  busy         out  1       1 while clear sweep in progress
//  clear_done   out  1       one-cycle pulse on final sweep write
//  perr_inject  in   1       [RAM_PARITY_EN only] invert stored parity on write
//  parity_err   out  1       [RAM_PARITY_EN only] parity mismatch on read word
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=CLEAR, ptr=0, busy=1, clear_done=0, out=0.
//    Array contents are not reset directly; the sweep zeroes them.
//  - States: CLEAR, IDLE.
//    CLEAR: each clk: mem[ptr]<=0, ptr<=ptr+1. On ptr==DEPTH-1: write, clear_done=1
//      that cycle (registered, visible the cycle after that final edge),
//      state->IDLE, busy=0. Sweep = exactly DEPTH cycles after rst_n release.
//    CLEAR + clear=1: ptr<=0 (sweep restarts; clear_done not pulsed).
//    IDLE + clear=1: state->CLEAR, ptr<=0, busy=1 next cycle; no write that edge.
//    IDLE + load=1 (clear=0): mem[address]<=in on clk rise; out shows new value
//      from next cycle (Hack RAMn semantics). load=1 && clear=1: clear wins,
//      write dropped.
//  - load ignored while busy=1; out forced to 0 while busy=1.
//  - Read: out = mem[address] combinationally when busy=0; write-then-read same
//    address returns old data until the clock edge.
//  - ptr is ADDR_W bits, wraps DEPTH-1->0 only via transition to IDLE.
//  - rst_n asserted mid-sweep or mid-write: immediate return to CLEAR, ptr=0;
//    any in-flight write is lost.
// CONFIGURATION
//  RAM_PARITY_EN defined: each word stores one extra even-parity bit
//    (^in ^ perr_inject) on load; sweep stores parity 0. parity_err =
//    (^out_word != stored_parity) && !busy, combinational. Ports present.
//  RAM_PARITY_EN undefined: no parity storage; perr_inject/parity_err absent.
// TESTING (ADDR_W=4, DEPTH=16, WIDTH=16)
//  1 Reset: rst_n 0->1 -> busy=1 exactly 16 cycles, clear_done pulses once,
//    then all 16 addresses read 16'h0000.
//  2 Write/read: load 16'hBEEF @addr 5 -> out=16'hBEEF next cycle at addr 5;
//    addr 6 still 16'h0000; same-cycle read before edge returns old value.
//  3 Busy lockout: load 16'h1234 @addr 3 during sweep -> after busy=0, addr 3
//    reads 16'h0000.
//  4 Clear request: fill all with 16'hA5A5, pulse clear with load=1 @addr 0
//    -> write dropped, busy 16 cycles, all read 0; clear re-asserted mid-sweep
//    at ptr=8 -> busy extends to 16 further cycles.
//  5 Async reset mid-sweep at ptr=10 -> busy stays 1, sweep restarts, 16 cycles
//    after release.
//  6 RAM_PARITY_EN: write 16'h0001 perr_inject=1 @addr 2 -> parity_err=1 reading
//    addr 2, 0 at addr 4; rewrite with perr_inject=0 -> parity_err=0.

Source files
------------

// File: rtl/ram_n_clr.sv
// Parametrised Hack-style RAM (WIDTH x 2**ADDR_W) with a clear sweep engine.
// Ports: clk, rst_n (async low), in, address, load, clear -> out, busy,
//   clear_done. Optional RAM_PARITY_EN adds perr_inject in, parity_err out.
// After reset or a clear request every word is swept to zero while busy=1.
module ram_n_clr #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
`ifdef RAM_PARITY_EN
  input  logic              perr_inject,
  output logic              parity_err,
`endif
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

`ifdef RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  logic [MW-1:0]     mem [DEPTH];
  logic [MW-1:0]     rd_word;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [MW-1:0]     wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      ptr        <= '0;
      busy       <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          // A new request restarts the sweep and suppresses the pulse
          if (clear) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            ptr        <= '0;
            state      <= S_IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_IDLE: begin
          if (clear) begin
            state <= S_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= S_CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Sweep writes zero (parity 0 too); user write only when idle
  // and no clear request on the same edge.
  always_comb begin
    we = 1'b0;
    wa = address;
    wd = '0;
    if (state == S_CLEAR) begin
      we = 1'b1;
      wa = ptr;
    end else if (load && !clear) begin
      we = 1'b1;
`ifdef RAM_PARITY_EN
      wd = {(^in) ^ perr_inject, in};
`else
      wd = in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem[wa] <= wd;
    end
  end

  assign rd_word = mem[address];
  assign out     = busy ? '0 : rd_word[WIDTH-1:0];

`ifdef RAM_PARITY_EN
  assign parity_err = !busy &&
    ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH]);
`endif

endmodule

// File: tb/tb_ram_n_clr.sv
// Bench for ram_n_clr at ADDR_W=4, WIDTH=16 against an array model.
// Define RAM_PARITY_EN to also exercise the parity option.
module tb_ram_n_clr;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  din;
  logic [AW-1:0] address;
  logic          load;
  logic          clear;
  logic [W-1:0]  dout;
  logic          busy;
  logic          clear_done;
`ifdef RAM_PARITY_EN
  logic          perr_inject;
  logic          parity_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model [D];

  ram_n_clr #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (din),
    .address    (address),
    .load       (load),
    .clear      (clear),
`ifdef RAM_PARITY_EN
    .perr_inject(perr_inject),
    .parity_err (parity_err),
`endif
    .out        (dout),
    .busy       (busy),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples busy once per cycle until it drops (bounded).
  task automatic count_busy(output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (clear_done !== 1'b0) pulses++;
      tick();
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < D; i++) model[i] = '0;
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i < D; i++) begin
      address = AW'(i);
      #1;
      total++;
      if (dout !== model[i]) begin
        bad++;
        $display("FAIL %s addr=%0d got=%h exp=%h",
                 nm, i, dout, model[i]);
      end
    end
  endtask

  task automatic test_reset();
    int n, p;
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (busy !== 1'b1 || dout !== '0 || clear_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state busy=%b out=%h done=%b exp 1/0/0",
               busy, dout, clear_done);
    end
    rst_n = 1'b1;
    count_busy(n, p);
    total++;
    if (n != D || p != 0) begin
      bad++;
      $display("FAIL reset_sweep cycles=%0d early_done=%0d exp %0d/0",
               n, p, D);
    end
    total++;
    if (clear_done !== 1'b1) begin
      bad++;
      $display("FAIL reset_done got=%b exp=1", clear_done);
    end
    tick();
    total++;
    if (clear_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done_once got=%b exp=0", clear_done);
    end
    model_zero();
    check_all("reset_zero");
  endtask

  task automatic test_write_read();
    address = 4'd5;
    din     = 16'hBEEF;
    load    = 1'b1;
    #1;
    total++;
    if (dout !== model[5]) begin
      bad++;
      $display("FAIL old_before_edge got=%h exp=%h", dout, model[5]);
    end
    tick();
    load = 1'b0;
    model[5] = 16'hBEEF;
    total++;
    if (dout !== 16'hBEEF) begin
      bad++;
      $display("FAIL write_read got=%h exp=beef", dout);
    end
    address = 4'd6;
    #1;
    total++;
    if (dout !== model[6]) begin
      bad++;
      $display("FAIL neighbour got=%h exp=%h", dout, model[6]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          ld;
    for (int i = 0; i < 60; i++) begin
      a  = AW'($urandom_range(0, D - 1));
      d  = W'($urandom);
      ld = 1'($urandom_range(0, 1));
      address = a;
      din     = d;
      load    = ld;
      #1;
      total++;
      if (dout !== model[a]) begin
        bad++;
        $display("FAIL rand_pre i=%0d got=%h exp=%h",
                 i, dout, model[a]);
      end
      tick();
      load = 1'b0;
      if (ld) model[a] = d;
      total++;
      if (dout !== model[a] || busy !== 1'b0) begin
        bad++;
        $display("FAIL rand_post i=%0d got=%h exp=%h busy=%b",
                 i, dout, model[a], busy);
      end
    end
    check_all("rand_final");
  endtask

  task automatic test_busy_lockout();
    int n, p;
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    address = 4'd3;
    din     = 16'h1234;
    load    = 1'b1;
    repeat (5) tick();
    load = 1'b0;
    count_busy(n, p);
    model_zero();
    total++;
    if (n != D - 5) begin
      bad++;
      $display("FAIL lockout_len got=%0d exp=%0d", n, D - 5);
    end
    address = 4'd3;
    #1;
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL lockout got=%h exp=0000", dout);
    end
  endtask

  task automatic test_clear_request();
    int n, p, early;
    for (int i = 0; i < D; i++) begin
      address = AW'(i);
      din     = 16'hA5A5;
      load    = 1'b1;
      tick();
      model[i] = 16'hA5A5;
    end
    load = 1'b0;
    check_all("fill");
    address = 4'd0;
    din     = 16'hFFFF;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    load    = 1'b0;
    clear   = 1'b0;
    address = 4'd15;
    #1;
    total++;
    if (dout !== 16'h0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL out_forced got=%h busy=%b exp 0000/1",
               dout, busy);
    end
    count_busy(n, p);
    model_zero();
    total++;
    if (n != D || p != 0 || clear_done !== 1'b1) begin
      bad++;
      $display("FAIL clear_len got=%0d done=%b exp %0d/1",
               n, clear_done, D);
    end
    check_all("clear_zero");
    // Restart at ptr=8: 8 samples, the restart sample, then D more
    clear = 1'b1;
    tick();
    clear = 1'b0;
    early = 0;
    for (int k = 0; k < 8; k++) begin
      if (clear_done !== 1'b0) early++;
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy(n, p);
    total++;
    if (n != D || p + early != 0) begin
      bad++;
      $display("FAIL restart_len got=%0d pulses=%0d exp %0d/0",
               n, p + early, D);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n, p;
    address = 4'd7;
    din     = 16'h7777;
    load    = 1'b1;
    tick();
    load = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || dout !== '0) begin
      bad++;
      $display("FAIL async_rst busy=%b out=%h exp 1/0000", busy, dout);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    count_busy(n, p);
    total++;
    if (n != D || p != 0) begin
      bad++;
      $display("FAIL rst_restart got=%0d exp=%0d", n, D);
    end
    model_zero();
    check_all("rst_zero");
    // A write racing reset is lost
    address = 4'd9;
    din     = 16'h9999;
    load    = 1'b1;
    rst_n   = 1'b0;
    tick();
    load  = 1'b0;
    rst_n = 1'b1;
    count_busy(n, p);
    address = 4'd9;
    #1;
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL rst_write_lost got=%h exp=0000", dout);
    end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    address     = 4'd2;
    din         = 16'h0001;
    load        = 1'b1;
    perr_inject = 1'b1;
    tick();
    load        = 1'b0;
    perr_inject = 1'b0;
    total++;
    if (parity_err !== 1'b1) begin
      bad++;
      $display("FAIL perr_inj got=%b exp=1", parity_err);
    end
    address = 4'd4;
    #1;
    total++;
    if (parity_err !== 1'b0) begin
      bad++;
      $display("FAIL perr_clean got=%b exp=0", parity_err);
    end
    address = 4'd2;
    load    = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (parity_err !== 1'b0 || dout !== 16'h0001) begin
      bad++;
      $display("FAIL perr_rewrite err=%b out=%h exp 0/0001",
               parity_err, dout);
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    din     = '0;
    address = '0;
    load    = 1'b0;
    clear   = 1'b0;
`ifdef RAM_PARITY_EN
    perr_inject = 1'b0;
`endif
    test_reset();
    test_write_read();
    test_random();
    test_busy_lockout();
    test_clear_request();
    test_reset_mid_sweep();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
